// File: rtl/uart_tx_fifo_param_if.sv
// Host-side bundle of the UART transmitter: FIFO write port plus line and status outputs.
interface uart_tx_fifo_param_if #(
    parameter int DBITS    = 8,
    parameter int FIFO_EXP = 2
);
    logic                write_uart;
    logic [DBITS-1:0]    write_data;
    logic                clear_overflow;
    logic                tx;
    logic                tx_busy;
    logic                fifo_full;
    logic                fifo_empty;
    logic [FIFO_EXP:0]   fifo_count;
    logic                overflow;

    modport master (
        output write_uart, write_data, clear_overflow,
        input  tx, tx_busy, fifo_full, fifo_empty, fifo_count, overflow
    );

    modport slave (
        input  write_uart, write_data, clear_overflow,
        output tx, tx_busy, fifo_full, fifo_empty, fifo_count, overflow
    );
endinterface

// File: rtl/uart_tx_fifo_param.sv
// UART transmitter with configurable data width, parity and stop bits, fed by a small
// circular write FIFO with registered occupancy flags and a sticky overflow flag.
module uart_tx_fifo_param #(
    parameter int DBITS       = 8,
    parameter int SB_TICK     = 16,
    parameter int BR_LIMIT    = 651,
    parameter int BR_BITS     = 10,
    parameter int FIFO_EXP    = 2,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk_100MHz,
    input  logic                 reset,
    uart_tx_fifo_param_if.slave  bus
);
    localparam int DEPTH = 2 ** FIFO_EXP;
    localparam int SC_W  = $clog2(2 * SB_TICK);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [DBITS-1:0]    mem [DEPTH];
    logic [FIFO_EXP-1:0] wptr, rptr;
    logic [FIFO_EXP:0]   count, cnt_nxt;
    logic                full_r, empty_r, ovf_r;

    state_t              state;
    logic [BR_BITS-1:0]  br_cnt;
    logic [SC_W-1:0]     s_cnt;
    logic [3:0]          n_cnt;
    logic [DBITS-1:0]    shreg;
    logic                par_bit;
    logic                tx_r, busy_r;

    logic                pop, push, tick, bit_end, stop_end;
    logic [DBITS-1:0]    rd_data;

    // A pop only happens from IDLE, so a full FIFO still accepts a write on that cycle.
    assign pop      = (state == IDLE) && !empty_r;
    assign push     = bus.write_uart && (!full_r || pop);
    assign rd_data  = mem[rptr];
    assign tick     = (state != IDLE) && (br_cnt == BR_BITS'(BR_LIMIT - 1));
    assign bit_end  = tick && (s_cnt == SC_W'(SB_TICK - 1));
    assign stop_end = tick && (s_cnt == SC_W'(STOP_BITS * SB_TICK - 1));
    assign cnt_nxt  = count + (FIFO_EXP+1)'(push) - (FIFO_EXP+1)'(pop);

    always_ff @(posedge clk_100MHz) begin
        if (push) mem[wptr] <= bus.write_data;
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
            ovf_r   <= 1'b0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            count   <= cnt_nxt;
            full_r  <= (cnt_nxt == (FIFO_EXP+1)'(DEPTH));
            empty_r <= (cnt_nxt == '0);
            if (bus.write_uart && !push) ovf_r <= 1'b1;
            else if (bus.clear_overflow) ovf_r <= 1'b0;
        end
    end

    // Baud counter idles at 0, so the first tick of a frame lands BR_LIMIT clocks after START entry.
    always_ff @(posedge clk_100MHz) begin
        if (reset || state == IDLE) br_cnt <= '0;
        else if (tick)              br_cnt <= '0;
        else                        br_cnt <= br_cnt + 1'b1;
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state   <= IDLE;
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
            s_cnt   <= '0;
            n_cnt   <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
        end else begin
            if (tick) s_cnt <= s_cnt + 1'b1;
            case (state)
                IDLE: begin
                    if (pop) begin
                        shreg   <= rd_data;
                        par_bit <= (^rd_data) ^ (PARITY_MODE == 2);
                        state   <= START;
                        tx_r    <= 1'b0;
                        busy_r  <= 1'b1;
                        s_cnt   <= '0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        s_cnt <= '0;
                        n_cnt <= '0;
                        state <= DATA;
                        tx_r  <= shreg[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        s_cnt <= '0;
                        if (n_cnt == 4'(DBITS - 1)) begin
                            if (PARITY_MODE != 0) begin
                                state <= PARITY;
                                tx_r  <= par_bit;
                            end else begin
                                state <= STOP;
                                tx_r  <= 1'b1;
                            end
                        end else begin
                            n_cnt <= n_cnt + 1'b1;
                            shreg <= shreg >> 1;
                            tx_r  <= shreg[1];
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        s_cnt <= '0;
                        state <= STOP;
                        tx_r  <= 1'b1;
                    end
                end
                STOP: begin
                    if (stop_end) begin
                        s_cnt  <= '0;
                        state  <= IDLE;
                        tx_r   <= 1'b1;
                        busy_r <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    tx_r   <= 1'b1;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx         = tx_r;
    assign bus.tx_busy    = busy_r;
    assign bus.fifo_full  = full_r;
    assign bus.fifo_empty = empty_r;
    assign bus.fifo_count = count;
    assign bus.overflow   = ovf_r;
endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Four transmitter configurations run side by side against a time-based frame model:
// 8N1, 8E2, 8O2 and 9N1, all at 16 clocks per bit.
module tb_uart_tx_fifo_param;
    localparam int BIT_CLKS = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       w   [4];
    logic [8:0] d   [4];
    logic       clr [4];

    int checks = 0, passes = 0;

    // Reference: FIFO as a ring of words, transmitter as "cycles into frame" plus the frame bit list.
    int   cdb [4], cpar [4], cstop [4];
    int   mq [4][4];
    int   mh [4], ms [4], mt [4], flen [4];
    logic mo [4];
    logic fb [4][16];
    int   busycnt [4];

    always #5 clk = ~clk;

    uart_tx_fifo_param_if #(.DBITS(8), .FIFO_EXP(2)) ia ();
    uart_tx_fifo_param_if #(.DBITS(8), .FIFO_EXP(2)) ib ();
    uart_tx_fifo_param_if #(.DBITS(8), .FIFO_EXP(2)) ic ();
    uart_tx_fifo_param_if #(.DBITS(9), .FIFO_EXP(2)) id ();

    assign ia.write_uart = w[0]; assign ia.write_data = d[0][7:0]; assign ia.clear_overflow = clr[0];
    assign ib.write_uart = w[1]; assign ib.write_data = d[1][7:0]; assign ib.clear_overflow = clr[1];
    assign ic.write_uart = w[2]; assign ic.write_data = d[2][7:0]; assign ic.clear_overflow = clr[2];
    assign id.write_uart = w[3]; assign id.write_data = d[3];      assign id.clear_overflow = clr[3];

    uart_tx_fifo_param #(.DBITS(8), .SB_TICK(4), .BR_LIMIT(4), .FIFO_EXP(2), .PARITY_MODE(0), .STOP_BITS(1))
        ua (.clk_100MHz(clk), .reset(rst), .bus(ia));
    uart_tx_fifo_param #(.DBITS(8), .SB_TICK(4), .BR_LIMIT(4), .FIFO_EXP(2), .PARITY_MODE(1), .STOP_BITS(2))
        ub (.clk_100MHz(clk), .reset(rst), .bus(ib));
    uart_tx_fifo_param #(.DBITS(8), .SB_TICK(4), .BR_LIMIT(4), .FIFO_EXP(2), .PARITY_MODE(2), .STOP_BITS(2))
        uc (.clk_100MHz(clk), .reset(rst), .bus(ic));
    uart_tx_fifo_param #(.DBITS(9), .SB_TICK(4), .BR_LIMIT(4), .FIFO_EXP(2), .PARITY_MODE(0), .STOP_BITS(1))
        ud (.clk_100MHz(clk), .reset(rst), .bus(id));

    // {tx, tx_busy, fifo_full, fifo_empty, fifo_count[2:0], overflow}
    function automatic logic [7:0] outs(int k);
        case (k)
            0:       return {ia.tx, ia.tx_busy, ia.fifo_full, ia.fifo_empty, ia.fifo_count, ia.overflow};
            1:       return {ib.tx, ib.tx_busy, ib.fifo_full, ib.fifo_empty, ib.fifo_count, ib.overflow};
            2:       return {ic.tx, ic.tx_busy, ic.fifo_full, ic.fifo_empty, ic.fifo_count, ic.overflow};
            default: return {id.tx, id.tx_busy, id.fifo_full, id.fifo_empty, id.fifo_count, id.overflow};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_update(input int k);
        int  word, n;
        logic pop, acc;
        if (rst) begin
            mh[k] = 0; ms[k] = 0; mt[k] = -1; mo[k] = 1'b0;
            return;
        end
        pop = (mt[k] == -1) && (ms[k] > 0);
        acc = w[k] && (ms[k] < 4 || pop);
        if (mt[k] >= 0) begin
            mt[k]++;
            if (mt[k] == flen[k]) mt[k] = -1;
        end
        if (pop) begin
            word  = mq[k][mh[k]];
            mh[k] = (mh[k] + 1) % 4;
            ms[k]--;
            fb[k][0] = 1'b0;
            for (int i = 0; i < cdb[k]; i++) fb[k][1+i] = word[i];
            n = 1 + cdb[k];
            if (cpar[k] != 0) begin
                fb[k][n] = ((^word) != 0) ^ (cpar[k] == 2);
                n++;
            end
            for (int i = 0; i < cstop[k]; i++) fb[k][n+i] = 1'b1;
            flen[k] = (n + cstop[k]) * BIT_CLKS;
            mt[k]   = 0;
        end
        if (acc) begin
            mq[k][(mh[k] + ms[k]) % 4] = int'(d[k]) & ((1 << cdb[k]) - 1);
            ms[k]++;
        end
        if (w[k] && !acc) mo[k] = 1'b1;
        else if (clr[k])  mo[k] = 1'b0;
    endtask

    task automatic step();
        logic [7:0] o;
        logic       etx;
        @(posedge clk);
        for (int k = 0; k < 4; k++) model_update(k);
        #1;
        for (int k = 0; k < 4; k++) begin
            o   = outs(k);
            etx = (mt[k] == -1) ? 1'b1 : fb[k][mt[k] / BIT_CLKS];
            chk($sformatf("u%0d_tx", k),    16'(o[7]),   16'(etx));
            chk($sformatf("u%0d_busy", k),  16'(o[6]),   16'(mt[k] != -1));
            chk($sformatf("u%0d_full", k),  16'(o[5]),   16'(ms[k] == 4));
            chk($sformatf("u%0d_empty", k), 16'(o[4]),   16'(ms[k] == 0));
            chk($sformatf("u%0d_count", k), 16'(o[3:1]), 16'(ms[k]));
            chk($sformatf("u%0d_ovf", k),   16'(o[0]),   16'(mo[k]));
            busycnt[k] += int'(o[6]);
        end
    endtask

    task automatic push(input int k, input logic [8:0] v);
        w[k] = 1'b1; d[k] = v;
        step();
        w[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k, input int budget, input string tag);
        logic [7:0] o;
        for (int i = 0; i < budget && !(mt[k] == -1 && ms[k] == 0); i++) step();
        o = outs(k);
        chk(tag, 16'({o[6], o[4]}), 16'b01);
    endtask

    initial begin
        logic [7:0] o;
        logic       d9 [9];
        d9 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        cdb   = '{8, 8, 8, 9};
        cpar  = '{0, 1, 2, 0};
        cstop = '{1, 2, 2, 1};
        for (int k = 0; k < 4; k++) begin
            w[k] = 1'b0; d[k] = '0; clr[k] = 1'b0;
            mh[k] = 0; ms[k] = 0; mt[k] = -1; mo[k] = 1'b0; flen[k] = 0; busycnt[k] = 0;
        end
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        step();
        o = outs(0);
        chk("reset_state", 16'(o), 16'b1001_0000);

        // One frame on every configuration at once: 0xAA 8N1, 0x07 8E2 / 8O2, 0x1A5 9N1.
        for (int k = 0; k < 4; k++) busycnt[k] = 0;
        w = '{1'b1, 1'b1, 1'b1, 1'b1};
        d = '{9'h0AA, 9'h007, 9'h007, 9'h1A5};
        step();
        w = '{1'b0, 1'b0, 1'b0, 1'b0};
        o = outs(0);
        chk("t1_count_after_push", 16'(o[3:1]), 16'd1);
        for (int i = 1; i <= 200; i++) begin
            step();
            if (i == 1) begin
                o = outs(0);
                chk("t1_count_after_pop", 16'(o[3:1]), 16'd0);
                chk("t1_start_low", 16'(o[7]), 16'd0);
            end
            for (int j = 0; j < 9; j++) begin
                if (i == 1 + BIT_CLKS * (1 + j) + 8) begin
                    o = outs(3);
                    chk($sformatf("t6_bit%0d", j), 16'(o[7]), 16'(d9[j]));
                    if (j < 8) begin
                        o = outs(0);
                        chk($sformatf("t1_bit%0d", j), 16'(o[7]), 16'(j % 2));
                    end
                end
            end
            if (i == 1 + BIT_CLKS * 9 + 8) begin
                o = outs(1);
                chk("t2_even_parity", 16'(o[7]), 16'd1);
                o = outs(2);
                chk("t2_odd_parity", 16'(o[7]), 16'd0);
            end
        end
        chk("t1_busy_len", 16'(busycnt[0]), 16'd160);
        chk("t2_even_len", 16'(busycnt[1]), 16'd192);
        chk("t2_odd_len",  16'(busycnt[2]), 16'd192);
        chk("t6_len",      16'(busycnt[3]), 16'd176);

        // Burst fills the FIFO behind the first popped word, then overflow handling.
        push(0, 9'h011); push(0, 9'h022); push(0, 9'h033); push(0, 9'h044); push(0, 9'h055);
        o = outs(0);
        chk("t3_full", 16'({o[5], o[3:1]}), 16'b1_100);
        push(0, 9'h066);
        o = outs(0);
        chk("t3_ovf_set", 16'(o[0]), 16'd1);
        w[0] = 1'b1; d[0] = 9'h067; clr[0] = 1'b1;
        step();
        w[0] = 1'b0;
        o = outs(0);
        chk("t3_set_wins", 16'(o[0]), 16'd1);
        step();
        clr[0] = 1'b0;
        o = outs(0);
        chk("t3_ovf_clear", 16'(o[0]), 16'd0);

        // Push on the exact cycle the idle FSM pops from a full FIFO.
        for (int i = 0; i < 300 && mt[0] != -1; i++) step();
        chk("t4_frame_end_seen", 16'(mt[0] == -1), 16'd1);
        push(0, 9'h077);
        o = outs(0);
        chk("t4_push_pop_full", 16'({o[6], o[5], o[3:1], o[0]}), 16'b11_100_0);
        wait_idle(0, 1000, "t4_drain");

        // Reset in the middle of DATA, then a fresh frame.
        push(0, 9'h03C);
        repeat (1 + BIT_CLKS * 4 + 8) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        o = outs(0);
        chk("t5_after_reset", 16'(o), 16'b1001_0000);
        busycnt[0] = 0;
        push(0, 9'($urandom_range(0, 255)));
        repeat (170) step();
        chk("t5_fresh_len", 16'(busycnt[0]), 16'd160);

        // Random pushes and clears on the 8N1 unit.
        repeat (1500) begin
            w[0]   = ($urandom_range(0, 99) < 4);
            d[0]   = 9'($urandom);
            clr[0] = ($urandom_range(0, 99) < 2);
            step();
        end
        w[0] = 1'b0; clr[0] = 1'b0;
        wait_idle(0, 1200, "rand_drain");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
